// File: rtl/blowfish_job_if.sv
// ============================================================================
//  Module   : blowfish_job_if
//  Brief    : Request / response / cipher-core bundle for blowfish_job_arbiter
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface blowfish_job_if;
  // host-side job requests
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_data;
  logic        req0_rt;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_data;
  logic        req1_rt;
  // response port
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_enc;
  logic [63:0] rsp_dec;
  logic        rsp_err;
  logic        busy;
  // cipher core controls and results
  logic        core_rst;
  logic        core_start;
  logic        core_enc;
  logic        core_dec;
  logic [63:0] core_plaintext;
  logic [63:0] core_encryptedtext;
  logic [63:0] core_decryptedtext;
  logic        core_encrypt_done;
  logic        core_decrypt_done;

  // environment side: job sources, response sink and the cipher core
  modport master (
    output req0_valid, req0_data, req0_rt, req1_valid, req1_data, req1_rt,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_enc, rsp_dec, rsp_err, busy,
    output rsp_ready,
    input  core_rst, core_start, core_enc, core_dec, core_plaintext,
    output core_encryptedtext, core_decryptedtext, core_encrypt_done, core_decrypt_done
  );

  // arbiter side
  modport slave (
    input  req0_valid, req0_data, req0_rt, req1_valid, req1_data, req1_rt,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_enc, rsp_dec, rsp_err, busy,
    input  rsp_ready,
    output core_rst, core_start, core_enc, core_dec, core_plaintext,
    input  core_encryptedtext, core_decryptedtext, core_encrypt_done, core_decrypt_done
  );
endinterface

`default_nettype wire

// File: rtl/blowfish_job_arbiter.sv
// ============================================================================
//  Module   : blowfish_job_arbiter
//  Brief    : Round-robin sharing of one Blowfish core between two requesters;
//             per job: core reset, encrypt, optional decrypt-back, response.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module blowfish_job_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  blowfish_job_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CRST     = 3'd1,
    ENC_WAIT = 3'd2,
    DEC_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t        state;
  logic          last;
  logic [TW-1:0] tmo;
  logic [63:0]   data_reg;
  logic          rt_reg;
  logic          id_reg;
  logic [63:0]   enc_reg;
  logic [63:0]   dec_reg;
  logic          err;

  logic any_req;
  logic gnt_id;

  // Grant selection: on a tie the requester not served last wins.
  always_comb begin
    any_req = bus.req0_valid | bus.req1_valid;
    gnt_id  = (bus.req0_valid & bus.req1_valid) ? ~last : bus.req1_valid;
  end

  // Ready pulses only in IDLE and never while the controller is held in reset.
  assign bus.req0_ready = ~rst & (state == IDLE) & bus.req0_valid & ~gnt_id;
  assign bus.req1_ready = ~rst & (state == IDLE) & bus.req1_valid &  gnt_id;

  // Core controls decode straight from the state register; the core is also
  // reset whenever the controller is.
  assign bus.core_rst       = rst | (state == CRST);
  assign bus.core_start     = (state == ENC_WAIT) | (state == DEC_WAIT);
  assign bus.core_enc       = (state == ENC_WAIT);
  assign bus.core_dec       = (state == DEC_WAIT);
  assign bus.core_plaintext = data_reg;

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_enc   = enc_reg;
  assign bus.rsp_dec   = dec_reg;
  assign bus.rsp_err   = err;
  assign bus.busy      = (state != IDLE);

  // Job sequencer: grant, core reset, encrypt/decrypt waits with timeout, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      tmo      <= '0;
      data_reg <= '0;
      rt_reg   <= 1'b0;
      id_reg   <= 1'b0;
      enc_reg  <= '0;
      dec_reg  <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            data_reg <= gnt_id ? bus.req1_data : bus.req0_data;
            rt_reg   <= gnt_id ? bus.req1_rt   : bus.req0_rt;
            id_reg   <= gnt_id;
            last     <= gnt_id;
            enc_reg  <= '0;
            dec_reg  <= '0;
            err      <= 1'b0;
            state    <= CRST;
          end
        end
        CRST: begin
          tmo   <= '0;
          state <= ENC_WAIT;
        end
        ENC_WAIT: begin
          if (bus.core_encrypt_done) begin
            // done beats a timeout landing in the same cycle
            enc_reg <= bus.core_encryptedtext;
            tmo     <= '0;
            state   <= rt_reg ? DEC_WAIT : RESP;
          end else if (tmo == TMO_LAST) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        DEC_WAIT: begin
          if (bus.core_decrypt_done) begin
            dec_reg <= bus.core_decryptedtext;
            state   <= RESP;
          end else if (tmo == TMO_LAST) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            err   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_blowfish_job_arbiter.sv
// ============================================================================
//  Module   : tb_blowfish_job_arbiter
//  Brief    : Directed bench with a delayed-done core stub and a response
//             scoreboard for blowfish_job_arbiter
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_blowfish_job_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // cycle stamp for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  blowfish_job_if bus ();

  blowfish_job_arbiter #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core stub: done becomes visible dly cycles after its enabling control rises
  int   dly = 10;
  logic hang = 1'b0;
  int   enc_cnt = 0;
  int   dec_cnt = 0;

  // stub counters, cleared by the core reset
  always @(posedge clk) begin
    if (bus.core_rst) begin
      enc_cnt <= 0;
      dec_cnt <= 0;
    end else begin
      if (bus.core_start && bus.core_enc && enc_cnt < dly) enc_cnt <= enc_cnt + 1;
      if (bus.core_start && bus.core_dec && dec_cnt < dly) dec_cnt <= dec_cnt + 1;
    end
  end

  assign bus.core_encrypt_done  = !hang && (enc_cnt >= dly);
  assign bus.core_decrypt_done  = !hang && (dec_cnt >= dly);
  assign bus.core_encryptedtext = ~bus.core_plaintext;
  assign bus.core_decryptedtext = bus.core_plaintext;

  typedef struct {
    logic        id;
    logic [63:0] enc;
    logic [63:0] dec;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t e;
  logic grant_log[$];
  logic rsp_log[$];
  logic exp_tmo = 1'b0;
  int   crst_cnt = 0;
  int   crst_cyc = 0;
  int   enc_cyc = 0;
  int   dec_cyc = 0;
  int   overlap = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic id, input logic [63:0] d, input logic rt);
    rsp_t x;
    x.id  = id;
    x.err = exp_tmo;
    x.enc = exp_tmo ? 64'h0 : ~d;
    x.dec = (exp_tmo || !rt) ? 64'h0 : d;
    exp_q.push_back(x);
    grant_log.push_back(id);
  endtask

  // Monitor: record accepts into the scoreboard, compare every consumed response
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.core_rst) begin
        crst_cnt++;
        crst_cyc = cyc;
      end
      if (bus.core_enc) enc_cyc++;
      if (bus.core_dec) dec_cyc++;
      if (bus.core_dec && (bus.core_enc || bus.rsp_valid || !bus.busy)) overlap++;
      if (bus.req0_valid && bus.req0_ready) push_exp(1'b0, bus.req0_data, bus.req0_rt);
      if (bus.req1_valid && bus.req1_ready) push_exp(1'b1, bus.req1_data, bus.req1_rt);
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_log.push_back(bus.rsp_id);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id",  {63'd0, bus.rsp_id},  {63'd0, e.id});
          chk("rsp_enc", bus.rsp_enc,          e.enc);
          chk("rsp_dec", bus.rsp_dec,          e.dec);
          chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e.err});
        end
      end
    end
  end

  task automatic wait_rsp(output int at);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rsp_wait_bound", 64'd0, 64'd1);
    at = cyc;
  endtask

  task automatic run_job(input int who, input logic [63:0] d, input logic rt,
                         output int t_acc, output int t_rsp);
    int n = 0;
    @(posedge clk); #1;
    if (who == 0) begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_rt = rt;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_rt = rt;
    end
    @(negedge clk);
    while (!((who == 0) ? bus.req0_ready : bus.req1_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_wait_bound", 64'd0, 64'd1);
    t_acc = cyc;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp(t_rsp);
  endtask

  int          ta, tr;
  int          unstable, rdy;
  logic [63:0] snap_enc, snap_dec;
  logic        snap_id, snap_err;

  initial begin
    rst            = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 64'hAAAA_5555_AAAA_5555;
    bus.req0_rt    = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 64'h0;
    bus.req1_rt    = 1'b0;
    bus.rsp_ready  = 1'b1;

    // reset values, with a request pending that must not be granted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_core_rst",   {63'd0, bus.core_rst},   64'd1);
    chk("rst_busy",       {63'd0, bus.busy},       64'd0);
    chk("rst_rsp_valid",  {63'd0, bus.rsp_valid},  64'd0);
    chk("rst_rsp_id",     {63'd0, bus.rsp_id},     64'd0);
    chk("rst_rsp_enc",    bus.rsp_enc,             64'd0);
    chk("rst_rsp_dec",    bus.rsp_dec,             64'd0);
    chk("rst_rsp_err",    {63'd0, bus.rsp_err},    64'd0);
    chk("rst_req0_ready", {63'd0, bus.req0_ready}, 64'd0);
    chk("rst_core_start", {63'd0, bus.core_start}, 64'd0);
    chk("rst_core_enc",   {63'd0, bus.core_enc},   64'd0);
    chk("rst_core_dec",   {63'd0, bus.core_dec},   64'd0);
    chk("rst_plaintext",  bus.core_plaintext,      64'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_core_rst", {63'd0, bus.core_rst}, 64'd0);
    chk("idle_busy",     {63'd0, bus.busy},     64'd0);

    // encrypt only
    #1; crst_cnt = 0; enc_cyc = 0;
    run_job(0, 64'h0123456789ABCDEF, 1'b0, ta, tr);
    chk("enc_latency",   64'(tr - ta), 64'd13);
    chk("enc_crst_cnt",  64'(crst_cnt), 64'd1);
    chk("enc_crst_at",   64'(crst_cyc - ta), 64'd1);
    chk("enc_core_cyc",  64'(enc_cyc), 64'd11);

    // round trip
    #1; dec_cyc = 0; overlap = 0;
    run_job(1, 64'hDEADBEEF00000001, 1'b1, ta, tr);
    chk("rt_latency",  64'(tr - ta), 64'd24);
    chk("rt_dec_cyc",  64'(dec_cyc), 64'd11);
    chk("rt_overlap",  64'(overlap), 64'd0);

    // round-robin with both requesters held valid
    #1; grant_log.delete(); rsp_log.delete();
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_data = 64'h1000_0000_0000_0000; bus.req0_rt = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 64'h2000_0000_0000_0002; bus.req1_rt = 1'b0;
    repeat (4) wait_rsp(tr);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rr_grant_cnt", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      logic g, r;
      g = (grant_log.size() > i) ? grant_log[i] : 1'bx;
      r = (rsp_log.size() > i)   ? rsp_log[i]   : 1'bx;
      chk("rr_grant_order", {63'd0, g}, 64'(i % 2));
      chk("rr_rsp_order",   {63'd0, r}, 64'(i % 2));
    end

    // backpressure: response held 20 cycles while another request waits
    bus.rsp_ready = 1'b0;
    run_job(0, 64'hCAFE_F00D_1234_5678, 1'b1, ta, tr);
    snap_id = bus.rsp_id; snap_enc = bus.rsp_enc; snap_dec = bus.rsp_dec; snap_err = bus.rsp_err;
    chk("bp_snap_enc", snap_enc, ~64'hCAFE_F00D_1234_5678);
    @(posedge clk); #1;
    bus.req1_valid = 1'b1; bus.req1_data = 64'h0F0F_0F0F_0F0F_0F0F; bus.req1_rt = 1'b0;
    unstable = 0; rdy = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_id !== snap_id || bus.rsp_enc !== snap_enc ||
          bus.rsp_dec !== snap_dec || bus.rsp_err !== snap_err) unstable++;
      if (bus.req0_ready || bus.req1_ready) rdy++;
    end
    chk("bp_stable",   64'(unstable), 64'd0);
    chk("bp_no_ready", 64'(rdy),      64'd0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {63'd0, bus.rsp_valid}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_accept", {63'd0, bus.req1_ready}, 64'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_rsp(tr);

    // timeout: done never arrives
    #1; exp_tmo = 1'b1; hang = 1'b1;
    run_job(0, 64'h1111_2222_3333_4444, 1'b0, ta, tr);
    chk("tmo_latency", 64'(tr - ta), 64'd18);
    #1; exp_tmo = 1'b0; hang = 1'b0;
    @(negedge clk);
    chk("tmo_err_cleared", {63'd0, bus.rsp_err}, 64'd0);

    // done lands on the last timeout cycle: done wins
    #1; dly = 15;
    run_job(1, 64'h5555_6666_7777_8888, 1'b0, ta, tr);
    chk("edge_latency", 64'(tr - ta), 64'd18);

    // normal job after the timeout
    #1; dly = 10;
    run_job(0, 64'h9999_AAAA_BBBB_CCCC, 1'b1, ta, tr);
    chk("post_tmo_latency", 64'(tr - ta), 64'd24);

    // mid-job reset during ENC_WAIT
    @(posedge clk); #1;
    bus.req1_valid = 1'b1; bus.req1_data = 64'h7777_0000_7777_0000; bus.req1_rt = 1'b1;
    @(negedge clk);
    chk("mr_accept", {63'd0, bus.req1_ready}, 64'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_in_enc_wait", {63'd0, bus.core_start}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_core_rst", {63'd0, bus.core_rst}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_busy",       {63'd0, bus.busy},       64'd0);
    chk("mr_rsp_valid",  {63'd0, bus.rsp_valid},  64'd0);
    chk("mr_core_start", {63'd0, bus.core_start}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    unstable = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) unstable++;
    end
    chk("mr_no_rsp", 64'(unstable), 64'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_data = 64'h0000_1111_0000_1111; bus.req0_rt = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 64'h2222_0000_2222_0000; bus.req1_rt = 1'b0;
    @(negedge clk);
    chk("mr_first_req0", {63'd0, bus.req0_ready}, 64'd1);
    chk("mr_first_req1", {63'd0, bus.req1_ready}, 64'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp(tr);

    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/blowfish_job_arbiter.md
# blowfish_job_arbiter

- Shares one Blowfish cipher core between two requesters.
- Per job:
  - arbitrates round-robin and latches the block;
  - resets the core for one cycle, which clears its sticky done flags and reloads its tables;
  - runs encryption, and optionally the decrypt-back pass;
  - returns the results through a valid/ready response port.
- Sits between the host-side job sources and the core, and owns all of the core's control inputs.

## Interface
- TIMEOUT, default 255: maximum cycles allowed per wait phase before the job is aborted. Must be ≥1.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- req0_valid, req1_valid  in  1  job request
- req0_ready, req1_ready  out  1  grant/accept pulse; the job is consumed in the cycle where valid&ready
- req0_data, req1_data  in  64  plaintext block
- req0_rt, req1_rt  in  1  round-trip: 1 = encrypt then decrypt, 0 = encrypt only
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  1  index of the requester that owns the response
- rsp_enc  out  64  ciphertext
- rsp_dec  out  64  decrypted block; 0 when rt=0
- rsp_err  out  1  job aborted by timeout
- busy  out  1  state != IDLE
- core_rst, core_start, core_enc, core_dec  out  1  core controls
- core_plaintext  out  64  latched job data
- core_encryptedtext, core_decryptedtext  in  64  core results
- core_encrypt_done, core_decrypt_done  in  1  core completion flags (sticky until core reset)

## Operation
- **States:** IDLE, CRST, ENC_WAIT, DEC_WAIT, RESP.
- **IDLE**
  - When any reqN_valid is high, grant one requester.
  - Both valid: grant the requester that was not granted last. Pointer `last` resets to 1, so req0 wins the first tie.
  - The granted reqN_ready is combinational and high only in IDLE.
  - Latch data, rt and id. Clear enc_reg and dec_reg to 0. Set `last` to the granted index. Go to CRST.
- **CRST**
  - core_rst=1 for exactly one cycle; all other core controls are 0. Go to ENC_WAIT.
- **ENC_WAIT**
  - Drive core_start=1, core_enc=1, core_dec=0, core_plaintext=latched data.
  - On core_encrypt_done=1: enc_reg<=core_encryptedtext; go to DEC_WAIT if rt=1, else RESP.
- **DEC_WAIT**
  - Drive core_start=1, core_enc=0, core_dec=1.
  - On core_decrypt_done=1: dec_reg<=core_decryptedtext; go to RESP.
- **Timeout**
  - Cycle counter `tmo` clears to 0 on entry to each wait state and increments each cycle in it.
  - If the done flag is low and tmo==TIMEOUT-1: set err<=1 and go to RESP. Unfinished result registers stay 0.
  - Done and the timeout in the same cycle: done wins, err=0.
- **RESP**
  - rsp_valid=1, with rsp_id/rsp_enc/rsp_dec/rsp_err driven from registers and held stable.
  - Core controls are 0 except core_plaintext, which holds.
  - On rsp_ready=1: clear err and go to IDLE. A new grant is possible on the next cycle.
- Done inputs are ignored outside their wait state.
- Requests are never accepted while busy; reqN_ready stays 0.
- **Reset:** core_rst = rst | (state==CRST), so a controller reset also resets the core.

## Timing
- Reset values:
  - state=IDLE, last=1, tmo=0;
  - rsp_valid=0, rsp_id=0, rsp_enc=0, rsp_dec=0, rsp_err=0, busy=0;
  - reqN_ready=0, core_start/enc/dec=0, core_plaintext=0;
  - core_rst=1 while rst is high.
- Accept at cycle T (IDLE, valid&ready). CRST at T+1. ENC_WAIT from T+2.
- Done sampled at cycle D leads to rsp_valid at D+1.
- Timeout path: ENC_WAIT entered at E gives rsp_valid at E+TIMEOUT, with err=1.
- Minimum job latency with an immediate done: accept to rsp_valid = 3 cycles for rt=0, 4 for rt=1.
- Reset mid-job: the job is dropped, no response is produced, and outputs return to reset values on the next edge.

## Test plan
Core stub: done rises 10 cycles after its enabling control; encryptedtext = ~plaintext; decryptedtext = original plaintext.

- **Encrypt only.** req0 data=64'h0123456789ABCDEF, rt=0, rsp_ready=1 → one core_rst pulse at T+1; rsp_valid at T+13; rsp_id=0, rsp_enc=64'hFEDCBA9876543210, rsp_dec=0, err=0.
- **Round trip.** req1 data=64'hDEADBEEF00000001, rt=1 → rsp_enc=64'h21524110FFFFFFFE, rsp_dec=64'hDEADBEEF00000001, core_dec high only during DEC_WAIT.
- **Round-robin.** req0 and req1 held valid for 4 jobs → grants alternate 0,1,0,1; rsp_id follows the same order.
- **Backpressure.** rsp_ready=0 for 20 cycles → rsp_valid and all payload stable; no reqN_ready; accept is possible on the cycle after rsp_ready=1.
- **Timeout.** TIMEOUT=16, stub never asserts done → rsp_valid 16 cycles after ENC_WAIT entry, rsp_err=1, rsp_enc=0; the next job completes normally with err=0.
- **Mid-job reset.** Assert rst in ENC_WAIT → core_rst=1 and busy=0 next cycle; no rsp_valid; the first job after reset is granted to req0.
